// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between the UART controller and the transmitter.
//
// Signals:
//   in_data   byte to send, meaningful only while in_valid is high
//   in_valid  controller has a byte for the transmitter
//   in_ready  transmitter holding register is empty
//
// Modports:
//   master  controller side (drives data/valid, observes ready)
//   slave   transmitter side (observes data/valid, drives ready)
interface uart_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8-N-1 UART transmitter with a one-byte holding register.
//
// A byte is accepted from the controller on any clock edge where in_valid and in_ready are both
// high. It waits in the holding register until the shift stage is free, so the next byte can be
// queued while the current frame is still shifting out. Frames are sent LSB first:
// start (0), data bits 0..7, [parity], STOP_BITS stop bits (1). Each bit lasts KBAUD clocks,
// matching the bit timing of the companion receiver.
//
// Optional feature (compile-time macro UART_TX_PARITY_EN):
//   defined   - an even-parity bit is inserted between data bit 7 and the stop bits
//   undefined - plain 8-N-1 framing, no parity logic
//
// Parameters:
//   KBAUD      clocks per bit, must be >= 2
//   STOP_BITS  number of stop bits, 1 or 2
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   host     byte handshake (uart_tx_if.slave): in_data, in_valid, in_ready
//   out_tx   serial line, registered, idle high
//   Tx_done  one-clock pulse during the last clock of the final stop bit
//   busy     frame in progress or a byte waiting in the holding register
module uart_tx #(
    parameter int unsigned KBAUD     = 14'd10416,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_tx_if.slave   host,
    output logic       out_tx,
    output logic       Tx_done,
    output logic       busy
);

    localparam int unsigned CW = (KBAUD > 1) ? $clog2(KBAUD) : 1;
    localparam logic [CW-1:0] BaudLast = CW'(KBAUD - 1);
    localparam logic [CW-1:0] BaudOne  = CW'(1);
    localparam logic          StopLast = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e         state;
    logic [7:0]     hold;
    logic           hold_full;
    logic [7:0]     shifter;
    logic [CW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic           stop_idx;
    logic           in_ready_q;

    logic accept;
    logic last_stop;
    logic bit_end;
    logic frame_end;
    logic load;
    logic idle_next;
    logic hold_full_d;
    logic busy_d;

    assign host.in_ready = in_ready_q;

    // Handshake, shift-stage load and the registered status flags are derived here so that
    // in_ready and busy reflect the state the FSM is about to enter, not the one it is leaving.
    always_comb begin
        accept      = host.in_valid & in_ready_q;
        last_stop   = (stop_idx == StopLast);
        bit_end     = (baud_cnt == '0);
        frame_end   = (state == StStop) & bit_end & last_stop;
        // The shifter takes the held byte either from idle or directly at the end of a frame,
        // which keeps back-to-back frames gap-free.
        load        = hold_full & ((state == StIdle) | frame_end);
        idle_next   = ((state == StIdle) & ~load) | (frame_end & ~hold_full);
        hold_full_d = accept | (hold_full & ~load);
        busy_d      = ~idle_next | hold_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            out_tx     <= 1'b1;
            Tx_done    <= 1'b0;
            busy       <= 1'b0;
            in_ready_q <= 1'b1;
            hold       <= '0;
            hold_full  <= 1'b0;
            shifter    <= '0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
        end else begin
            hold_full  <= hold_full_d;
            in_ready_q <= ~hold_full_d;
            busy       <= busy_d;
            Tx_done    <= 1'b0;

            if (accept) begin
                hold <= host.in_data;
            end
            if (load) begin
                shifter <= hold;
            end

            unique case (state)
                StIdle: begin
                    if (hold_full) begin
                        state    <= StStart;
                        out_tx   <= 1'b0;
                        baud_cnt <= BaudLast;
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        state    <= StData;
                        bit_idx  <= '0;
                        out_tx   <= shifter[0];
                        baud_cnt <= BaudLast;
                    end else begin
                        baud_cnt <= baud_cnt - BaudOne;
                    end
                end

                StData: begin
                    if (bit_end) begin
                        baud_cnt <= BaudLast;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state    <= StParity;
                            out_tx   <= ^shifter;
`else
                            state    <= StStop;
                            stop_idx <= 1'b0;
                            out_tx   <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            out_tx  <= shifter[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BaudOne;
                    end
                end

`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        state    <= StStop;
                        stop_idx <= 1'b0;
                        out_tx   <= 1'b1;
                        baud_cnt <= BaudLast;
                    end else begin
                        baud_cnt <= baud_cnt - BaudOne;
                    end
                end
`endif

                StStop: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            stop_idx <= 1'b0;
                            if (hold_full) begin
                                // Next frame starts on this edge: no idle bit between frames.
                                state    <= StStart;
                                out_tx   <= 1'b0;
                                baud_cnt <= BaudLast;
                            end else begin
                                state <= StIdle;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                            baud_cnt <= BaudLast;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BaudOne;
                        // Registered, so raising it one count early lands the pulse on the
                        // final clock of the last stop bit.
                        if ((baud_cnt == BaudOne) && last_stop) begin
                            Tx_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state  <= StIdle;
                    out_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// u_dut1 runs KBAUD=8, STOP_BITS=1 with a scoreboard-driven line monitor; u_dut2 runs
// KBAUD=4, STOP_BITS=2 and is checked cycle by cycle from the initial block.
module tb_uart_tx;

    localparam int K1 = 8;
    localparam int S1 = 1;
    localparam int K2 = 4;
    localparam int S2 = 2;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F1 = (9 + PAR + S1) * K1;
    localparam int F2 = (9 + PAR + S2) * K2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_if bus1 ();
    uart_tx_if bus2 ();

    logic tx1, done1, busy1;
    logic tx2, done2, busy2;

    uart_tx #(.KBAUD(K1), .STOP_BITS(S1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .host    (bus1),
        .out_tx  (tx1),
        .Tx_done (done1),
        .busy    (busy1)
    );

    uart_tx #(.KBAUD(K2), .STOP_BITS(S2)) u_dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .host    (bus2),
        .out_tx  (tx2),
        .Tx_done (done2),
        .busy    (busy2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         starts[$];
    int         dones[$];
    bit         in_frame = 1'b0;
    int         k1       = 0;
    logic [7:0] cur1     = 8'h00;
    int         frames   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected line level at clock k of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int k, input int kb);
        int idx;
        idx = k / kb;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR == 1 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Line monitor for u_dut1: a falling line outside a frame starts the next expected byte.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx1 === 1'b0) begin
                in_frame = 1'b1;
                k1 = 0;
                frames++;
                starts.push_back(cyc);
                chk("scoreboard_nonempty", exp_q.size() > 0, 1);
                cur1 = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            end
            if (in_frame) begin
                chk("tx1_bit", tx1, exp_bit(cur1, k1, K1));
                chk("done1_in_frame", done1, k1 == F1 - 1);
                chk("busy1_in_frame", busy1, 1);
                if (done1 === 1'b1) dones.push_back(cyc);
                k1++;
                if (k1 == F1) in_frame = 1'b0;
            end else begin
                chk("done1_idle", done1, 0);
            end
        end
    end

    task automatic send1(input logic [7:0] b);
        int n = 0;
        bus1.in_data  = b;
        bus1.in_valid = 1'b1;
        while (bus1.in_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("send1_ready_timeout", n < 1000, 1);
        exp_q.push_back(b);
        @(negedge clk);
        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(busy1 === 1'b0 && !in_frame && exp_q.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 2000, 1);
    endtask

    // Sends b on u_dut2 and checks every clock of the resulting frame.
    task automatic frame2(input logic [7:0] b);
        int n = 0;
        bus2.in_data  = b;
        bus2.in_valid = 1'b1;
        while (bus2.in_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("send2_ready_timeout", n < 1000, 1);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        chk("tx2_before_start", tx2, 1);
        for (int k = 0; k < F2; k++) begin
            @(negedge clk);
            chk("tx2_bit", tx2, exp_bit(b, k, K2));
            chk("done2", done2, k == F2 - 1);
        end
        @(negedge clk);
        chk("busy2_after", busy2, 0);
        chk("tx2_after", tx2, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus1.in_data  = 8'h00;
        bus1.in_valid = 1'b0;
        bus2.in_data  = 8'h00;
        bus2.in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tx1", tx1, 1);
        chk("rst_ready1", bus1.in_ready, 1);
        chk("rst_done1", done1, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_tx2", tx2, 1);
        chk("rst_ready2", bus2.in_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte from idle: latency, Tx_done position, busy release
        send1(8'hA5);
        chk("a5_tx_accept", tx1, 1);
        chk("a5_ready_accept", bus1.in_ready, 0);
        chk("a5_busy_accept", busy1, 1);
        @(negedge clk);
        chk("a5_tx_start", tx1, 0);
        chk("a5_ready_load", bus1.in_ready, 1);
        repeat (F1 - 1) @(negedge clk);
        chk("a5_done_last", done1, 1);
        chk("a5_busy_last", busy1, 1);
        @(negedge clk);
        chk("a5_done_after", done1, 0);
        chk("a5_busy_after", busy1, 0);
        chk("a5_tx_after", tx1, 1);
        wait_idle("a5_idle");

        // Back-to-back 0x00 then 0xFF with valid held high
        starts.delete();
        dones.delete();
        send1(8'h00);
        send1(8'hFF);
        chk("b2b_ready_held", bus1.in_ready, 0);
        repeat (F1 - 4) @(negedge clk);
        chk("b2b_ready_late", bus1.in_ready, 0);
        wait_idle("b2b_idle");
        chk("b2b_frames", starts.size(), 2);
        chk("b2b_gap", (starts.size() == 2) ? starts[1] - starts[0] : -1, F1);
        chk("b2b_dones", dones.size(), 2);
        chk("b2b_done_gap", (dones.size() == 2) ? dones[1] - dones[0] : -1, F1);

        // Three bytes under backpressure
        send1(8'h12);
        send1(8'h34);
        send1(8'h56);
        wait_idle("bp_idle");
        chk("bp_frames", frames, 6);

        // Reset during data bit 3 of 0x3C
        send1(8'h3C);
        repeat (1 + 4 * K1 + 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx1, 1);
        chk("rst_mid_busy", busy1, 0);
        chk("rst_mid_done", done1, 0);
        chk("rst_mid_ready", bus1.in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", busy1, 0);
        chk("post_rst_tx", tx1, 1);
        send1(8'h81);
        wait_idle("post_rst_idle");
        chk("total_frames", frames, 8);

        // Two stop bits, KBAUD=4; 0x07/0x03 also exercise parity when enabled
        frame2(8'h01);
        frame2(8'h07);
        frame2(8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
